// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: walks fetch/decode/exec/[mem]/write one stage at a time,
// pulsing each stage enable once and waiting for its done, with a per-stage watchdog.
module core_sequencer #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             halt_req,
   input  logic             fetch_done,
   input  logic             decode_done,
   input  logic             mem_need,
   input  logic             exec_done,
   input  logic             mem_done,
   input  logic             write_done,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             write_en,
   output logic             busy,
   output logic             error,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WRITE,
      S_ERROR
   } state_t;

   // The wait counter only has to reach TIMEOUT-1: the timeout fires on that cycle.
   localparam int             WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

   state_t           state, state_n;
   logic [WC_W-1:0]  wcnt, wcnt_n;
   logic             mem_lat, mem_lat_n;
   logic             halt_lat, halt_lat_n;
   logic [CNT_W-1:0] instret_n;
   logic             in_stage;
   logic             first_cycle;
   logic             stage_done;
   logic             fetch_en_n, decode_en_n, exec_en_n, mem_en_n, write_en_n;
   logic             busy_n, error_n;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold the old value.
   always_comb begin
      state_n     = state;
      wcnt_n      = wcnt + 1'b1;
      mem_lat_n   = mem_lat;
      halt_lat_n  = halt_lat;
      instret_n   = instret;
      in_stage    = (state != S_IDLE) && (state != S_ERROR);
      first_cycle = (wcnt == '0);
      stage_done  = 1'b0;

      if (in_stage) begin
         halt_lat_n = halt_lat | halt_req;
      end else begin
         wcnt_n = '0;
      end

      // A done in the enable cycle, or from a stage we are not in, is ignored.
      case (state)
         S_FETCH:  stage_done = fetch_done  && !first_cycle;
         S_DECODE: stage_done = decode_done && !first_cycle;
         S_EXEC:   stage_done = exec_done   && !first_cycle;
         S_MEM:    stage_done = mem_done    && !first_cycle;
         S_WRITE:  stage_done = write_done  && !first_cycle;
         default:  stage_done = 1'b0;
      endcase

      case (state)
         S_IDLE: begin
            if (start) state_n = S_FETCH;
         end
         S_FETCH: begin
            if (stage_done) state_n = S_DECODE;
         end
         S_DECODE: begin
            if (stage_done) begin
               state_n   = S_EXEC;
               mem_lat_n = mem_need;
            end
         end
         S_EXEC: begin
            if (stage_done) state_n = mem_lat ? S_MEM : S_WRITE;
         end
         S_MEM: begin
            if (stage_done) state_n = S_WRITE;
         end
         S_WRITE: begin
            if (stage_done) begin
               instret_n = instret + 1'b1;
               if (halt_lat || halt_req) begin
                  state_n    = S_IDLE;
                  halt_lat_n = 1'b0;
               end else begin
                  state_n = S_FETCH;
               end
            end
         end
         S_ERROR: state_n = S_ERROR;
         default: state_n = S_IDLE;
      endcase

      // A done landing on the last allowed cycle takes the normal transition.
      if (in_stage && !stage_done && (wcnt == WC_LAST)) begin
         state_n = S_ERROR;
      end

      if (state_n != state) wcnt_n = '0;

      fetch_en_n  = (state_n == S_FETCH)  && (state != S_FETCH);
      decode_en_n = (state_n == S_DECODE) && (state != S_DECODE);
      exec_en_n   = (state_n == S_EXEC)   && (state != S_EXEC);
      mem_en_n    = (state_n == S_MEM)    && (state != S_MEM);
      write_en_n  = (state_n == S_WRITE)  && (state != S_WRITE);
      busy_n      = (state_n != S_IDLE)   && (state_n != S_ERROR);
      error_n     = (state_n == S_ERROR);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         mem_lat   <= 1'b0;
         halt_lat  <= 1'b0;
         instret   <= '0;
         fetch_en  <= 1'b0;
         decode_en <= 1'b0;
         exec_en   <= 1'b0;
         mem_en    <= 1'b0;
         write_en  <= 1'b0;
         busy      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         wcnt      <= wcnt_n;
         mem_lat   <= mem_lat_n;
         halt_lat  <= halt_lat_n;
         instret   <= instret_n;
         fetch_en  <= fetch_en_n;
         decode_en <= decode_en_n;
         exec_en   <= exec_en_n;
         mem_en    <= mem_en_n;
         write_en  <= write_en_n;
         busy      <= busy_n;
         error     <= error_n;
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues expected enable pulses
// (stage, spacing, instret); a negedge monitor pops and compares each pulse.
module tb_core_sequencer;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 4;

   logic clk = 1'b0;
   logic rstn;
   logic start, halt_req, fetch_done, decode_done, mem_need, exec_done, mem_done, write_done;
   logic fetch_en, decode_en, exec_en, mem_en, write_en, busy, error;
   logic [CNT_W-1:0] instret;
   logic [4:0] env;

   core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
      .fetch_done(fetch_done), .decode_done(decode_done), .mem_need(mem_need),
      .exec_done(exec_done), .mem_done(mem_done), .write_done(write_done),
      .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
      .mem_en(mem_en), .write_en(write_en), .busy(busy), .error(error),
      .instret(instret)
   );

   always #5 clk = ~clk;
   assign env = {write_en, mem_en, exec_en, decode_en, fetch_en};

   typedef struct {
      int stage;  // 0 F, 1 D, 2 E, 3 M, 4 W
      int gap;    // cycles since previous enable; 0 = not checked
      int cnt;    // instret while the pulse is high
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;
   int fgap = 0;
   int cyc = 0;
   int last_cyc = 0;

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // Monitor: one comparison per observed enable pulse.
   always @(negedge clk) begin
      int   stg, gap;
      exp_t e;
      cyc++;
      if (env != 5'b0) begin
         gap = cyc - last_cyc;
         last_cyc = cyc;
         stg = 0;
         for (int i = 0; i < 5; i++) if (env[i]) stg = i;
         n_cmp++;
         if ($countones(env) != 1) begin
            n_err++;
            $display("FAIL enable onehot: got %b", env);
         end else if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected enable: got stage %0d at cycle %0d, expected none", stg, cyc);
         end else begin
            e = sb.pop_front();
            if (stg != e.stage || int'(instret) != e.cnt || (e.gap != 0 && gap != e.gap)) begin
               n_err++;
               $display("FAIL enable seq: got stage=%0d gap=%0d instret=%0d, expected stage=%0d gap=%0d instret=%0d",
                        stg, gap, instret, e.stage, e.gap, e.cnt);
            end
         end
      end
   end

   task automatic push(input int stage, input int gap);
      exp_t e;
      e.stage = stage;
      e.gap   = gap;
      e.cnt   = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic wait_en(input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (env[idx]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait enable %0d: got no pulse in 40 cycles, expected one", idx);
      end
   endtask

   // Answer one stage: done `dly` cycles after its enable. hmode 1 pulses halt
   // in the exec enable cycle, 2 with write_done, 3 also raises start.
   task automatic stage(input int idx, input int dly, input bit mneed, input bit spur, input int hmode);
      bit ok;
      wait_en(idx, ok);
      if (!ok) return;
      if (idx == 0) start = 1'b0;
      if (idx == 2 && hmode == 1) halt_req = 1'b1;
      if (spur && idx == 1) decode_done = 1'b1;
      if (spur && idx == 0) write_done = 1'b1;
      for (int j = 1; j < dly; j++) begin
         @(posedge clk); #1;
         halt_req    = 1'b0;
         decode_done = 1'b0;
         write_done  = spur && (idx == 0);
      end
      @(posedge clk); #1;
      halt_req    = 1'b0;
      decode_done = 1'b0;
      write_done  = 1'b0;
      case (idx)
         0: fetch_done  = 1'b1;
         1: begin decode_done = 1'b1; mem_need = mneed; end
         2: exec_done   = 1'b1;
         3: mem_done    = 1'b1;
         default: begin
            write_done = 1'b1;
            if (hmode >= 2) halt_req = 1'b1;
            if (hmode == 3) start = 1'b1;
         end
      endcase
      @(posedge clk); #1;
      {fetch_done, decode_done, exec_done, mem_done, write_done, mem_need, halt_req} = '0;
   endtask

   task automatic do_instr(input bit mneed, input int fd, input int dd, input int ed,
                           input int md, input int wd, input bit spur, input int hmode);
      push(0, fgap);
      push(1, fd + 1);
      push(2, dd + 1);
      if (mneed) push(3, ed + 1);
      push(4, (mneed ? md : ed) + 1);
      stage(0, fd, 1'b0, spur, hmode);
      stage(1, dd, mneed, spur, hmode);
      stage(2, ed, 1'b0, spur, hmode);
      if (mneed) stage(3, md, 1'b0, spur, hmode);
      stage(4, wd, 1'b0, spur, hmode);
      exp_cnt = (exp_cnt + 1) % 16;
      if (hmode != 0) begin
         check("halt busy", busy, 0);
         check("halt instret", instret, exp_cnt);
         fgap = (hmode == 3) ? wd + 2 : 0;
      end else begin
         fgap = wd + 1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global time limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      rstn = 1'b0;
      {start, halt_req, fetch_done, decode_done, mem_need, exec_done, mem_done, write_done} = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      check("reset enables", env, 0);
      check("reset busy", busy, 0);
      check("reset error", error, 0);
      check("reset instret", instret, 0);

      // Plain instructions, then mem / no-mem.
      start = 1'b1;
      fgap  = 0;
      do_instr(0, 1, 1, 1, 1, 1, 0, 0);
      do_instr(0, 1, 1, 1, 1, 1, 0, 0);
      check("instret after 2", instret, 2);
      do_instr(1, 1, 1, 1, 1, 1, 0, 0);
      do_instr(0, 1, 1, 1, 1, 1, 0, 0);

      // Spurious write_done in FETCH, decode_done in its enable cycle.
      do_instr(0, 2, 2, 1, 1, 1, 1, 0);
      // exec_done on the last cycle before timeout still wins.
      do_instr(0, 1, 1, TIMEOUT - 1, 1, 1, 0, 0);
      check("late done no error", error, 0);

      // Halt during EXEC: idle and silent until start.
      do_instr(1, 1, 1, 1, 1, 1, 0, 1);
      repeat (10) @(posedge clk);
      #1;
      check("halted busy", busy, 0);
      start = 1'b1;
      fgap  = 0;
      // Halt with write_done while start stays high: refetch after one idle cycle.
      do_instr(0, 1, 1, 1, 1, 1, 0, 3);
      do_instr(0, 1, 1, 1, 1, 1, 0, 0);

      // Run across the 4-bit wrap (9 done so far, 9 more).
      for (int k = 0; k < 9; k++) do_instr(k[0], 1, 1, 1, 1, 1, 0, 0);
      check("instret wrapped", instret, 2);

      // Watchdog on withheld exec_done.
      push(0, fgap);
      push(1, 2);
      push(2, 2);
      stage(0, 1, 1'b0, 1'b0, 0);
      stage(1, 1, 1'b0, 1'b0, 0);
      wait_en(2, ok);
      repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
      check("pre-timeout error", error, 0);
      check("pre-timeout busy", busy, 1);
      @(posedge clk); #1;
      check("timeout error", error, 1);
      check("timeout busy", busy, 0);
      exec_done = 1'b1;
      @(posedge clk); #1;
      exec_done  = 1'b0;
      write_done = 1'b1;
      fetch_done = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      {write_done, fetch_done, start} = '0;
      repeat (5) @(posedge clk);
      #1;
      check("error sticky", error, 1);
      check("error instret", instret, exp_cnt);
      rstn = 1'b0;
      #1;
      check("reset clears error", error, 0);
      check("reset clears instret", instret, 0);
      exp_cnt = 0;
      @(negedge clk) rstn = 1'b1;

      // Asynchronous reset in the middle of MEM.
      start = 1'b1;
      fgap  = 0;
      do_instr(0, 1, 1, 1, 1, 1, 0, 0);
      push(0, fgap);
      push(1, 2);
      push(2, 2);
      push(3, 2);
      stage(0, 1, 1'b0, 1'b0, 0);
      stage(1, 1, 1'b1, 1'b0, 0);
      stage(2, 1, 1'b0, 1'b0, 0);
      wait_en(3, ok);
      check("mid-mem instret", instret, 1);
      @(negedge clk); #1;
      rstn = 1'b0;
      #1;
      check("async rst mem_en", mem_en, 0);
      check("async rst busy", busy, 0);
      check("async rst instret", instret, 0);
      check("async rst enables", env, 0);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
